// File: rtl/scpu_runctl.sv
// rtl/scpu_runctl.sv - debug run controller: run/step/halt gating of the CPU clock-enable and register dump.
module scpu_runctl #(
  parameter int CNT_W = 16,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [CNT_W-1:0] cyc_limit,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             dump_done,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP, S_DUMP} state_t;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_HALT = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_HOST  = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_LIMIT = 3'd3;
  localparam logic [2:0] CAUSE_FAULT = 3'd4;
  localparam logic [2:0] CAUSE_STEP  = 3'd5;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_t           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       sel_q, sel_d;
  logic             skip_q, skip_d;
  logic             dvalid_q, dvalid_d;
  logic [4:0]       didx_q, didx_d;
  logic [31:0]      ddata_q, ddata_d;
  logic             dlast_q, dlast_d;
  logic             ddone_q, ddone_d;
  logic             cpu_en_c;
  logic             accept;
  logic             fault, bp_hit, limit_hit;

  always_comb begin
    fault     = (pc[1:0] != 2'b00);
    bp_hit    = bp_en && (pc == bp_addr) && !skip_q;
    limit_hit = (cyc_limit != '0) && (cnt_q >= cyc_limit);
    cmd_ready = (state_q == S_HALTED) || (state_q == S_RUN);
    accept    = cmd_valid && cmd_ready;

    state_d  = state_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    skip_d   = skip_q;
    dvalid_d = 1'b0;
    didx_d   = didx_q;
    ddata_d  = ddata_q;
    dlast_d  = 1'b0;
    ddone_d  = dlast_q;
    cpu_en_c = 1'b0;

    case (state_q)
      S_HALTED: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_d = S_RUN;
              cnt_d   = '0;
              skip_d  = 1'b1;
            end
            OP_STEP: state_d = S_STEP;
            OP_DUMP: begin
              state_d = S_DUMP;
              idx_d   = 5'd0;
              sel_d   = 5'd0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // The skip flag only masks the breakpoint for the very first RUN cycle.
        skip_d = 1'b0;
        if (fault || bp_hit || limit_hit) begin
          state_d = S_HALTED;
          cause_d = fault ? CAUSE_FAULT : (bp_hit ? CAUSE_BP : CAUSE_LIMIT);
        end else begin
          cpu_en_c = 1'b1;
          if (accept && cmd_op == OP_HALT) begin
            state_d = S_HALTED;
            cause_d = CAUSE_HOST;
          end
        end
      end
      S_STEP: begin
        state_d = S_HALTED;
        if (fault) begin
          cause_d = CAUSE_FAULT;
        end else begin
          cpu_en_c = 1'b1;
          cause_d  = CAUSE_STEP;
        end
      end
      S_DUMP: begin
        // reg_data belongs to sel_q this cycle; it is presented one cycle later.
        dvalid_d = 1'b1;
        didx_d   = idx_q;
        ddata_d  = reg_data;
        idx_d    = idx_q + 5'd1;
        sel_d    = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_HALTED;
          dlast_d = 1'b1;
          idx_d   = 5'd0;
          sel_d   = 5'd0;
        end
      end
      default: state_d = S_HALTED;
    endcase

    if (cpu_en_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_HALTED;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
      idx_q    <= 5'd0;
      sel_q    <= 5'd0;
      skip_q   <= 1'b0;
      dvalid_q <= 1'b0;
      didx_q   <= 5'd0;
      ddata_q  <= 32'd0;
      dlast_q  <= 1'b0;
      ddone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      skip_q   <= skip_d;
      dvalid_q <= dvalid_d;
      didx_q   <= didx_d;
      ddata_q  <= ddata_d;
      dlast_q  <= dlast_d;
      ddone_q  <= ddone_d;
    end
  end

  assign cpu_en     = cpu_en_c;
  assign reg_sel    = sel_q;
  assign dump_valid = dvalid_q;
  assign dump_idx   = didx_q;
  assign dump_data  = ddata_q;
  assign dump_done  = ddone_q;
  assign halt_cause = cause_q;
  assign cyc_cnt    = cnt_q;
  assign busy       = (state_q != S_HALTED);

endmodule

// File: tb/tb_scpu_runctl.sv
// tb/tb_scpu_runctl.sv - randomized self-checking bench for scpu_runctl with a simple CPU and register-file model.
module tb_scpu_runctl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic             cmd_ready;
  logic             bp_en = 1'b0;
  logic [31:0]      bp_addr = 32'd0;
  logic [CNT_W-1:0] cyc_limit = '0;
  logic [31:0]      pc;
  logic             cpu_en;
  logic [4:0]       reg_sel;
  logic [31:0]      reg_data;
  logic             dump_valid;
  logic [4:0]       dump_idx;
  logic [31:0]      dump_data;
  logic             dump_done;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] cyc_cnt;
  logic             busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [2:0] exp_cause = 3'd0;

  logic [31:0] cpu_pc = 32'd0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'd0;
  logic        flt = 1'b0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_load) cpu_pc <= pc_load_val;
    else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
  end

  assign pc = flt ? 32'h2 : cpu_pc;
  assign reg_data = rf[reg_sel];

  scpu_runctl #(.CNT_W(CNT_W), .NREG(32)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .bp_en(bp_en), .bp_addr(bp_addr), .cyc_limit(cyc_limit), .pc(pc), .cpu_en(cpu_en),
    .reg_sel(reg_sel), .reg_data(reg_data), .dump_valid(dump_valid), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_done(dump_done), .halt_cause(halt_cause), .cyc_cnt(cyc_cnt),
    .busy(busy)
  );

  task automatic send_cmd(input logic [1:0] op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // Called at the negedge right after RUN was accepted; counts enabled cycles until halted.
  task automatic measure_run(input int budget, output int en, output logic [31:0] stop_pc,
                             output bit timed_out);
    en = 0;
    stop_pc = 32'hffff_ffff;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (cpu_en) en++;
      else stop_pc = pc;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if ({busy, cpu_en, cmd_ready, dump_valid, dump_done} !== 5'b00100 || halt_cause !== 3'd0 ||
        cyc_cnt !== '0 || reg_sel !== 5'd0)
      $display("FAIL reset: busy=%b en=%b rdy=%b dv=%b dd=%b cause=%0d cnt=%0d sel=%0d, want 0 0 1 0 0 0 0 0",
               busy, cpu_en, cmd_ready, dump_valid, dump_done, halt_cause, cyc_cnt, reg_sel);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_breakpoint;
    int en;
    logic [31:0] sp;
    bit to;
    set_pc(32'h0);
    bp_en = 1'b1;
    bp_addr = 32'h48;
    cyc_limit = '0;
    send_cmd(2'd0);
    measure_run(200, en, sp, to);
    exp_cause = 3'd2;
    total_cnt++;
    if (to || en !== 18 || sp !== 32'h48 || halt_cause !== 3'd2 || cyc_cnt !== 16'd18)
      $display("FAIL bp_0x48: to=%0d en=%0d pc=%h cause=%0d cnt=%0d, want 0 18 00000048 2 18",
               to, en, sp, halt_cause, cyc_cnt);
    else pass_cnt++;
  endtask

  task automatic test_resume;
    send_cmd(2'd0);
    total_cnt++;
    if (cpu_en !== 1'b1) $display("FAIL resume_en: cpu_en=%b want 1", cpu_en);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (pc !== 32'h4c) $display("FAIL resume_pc: pc=%h want 0000004c", pc);
    else pass_cnt++;
    send_cmd(2'd2);
    exp_cause = 3'd1;
    total_cnt++;
    if (busy !== 1'b0 || halt_cause !== 3'd1)
      $display("FAIL host_halt: busy=%b cause=%0d want 0 1", busy, halt_cause);
    else pass_cnt++;
  endtask

  task automatic test_random_runs;
    int en, k, lim, exp_en;
    logic [31:0] sp, pc0, exp_pc;
    bit to;
    logic [2:0] ec;
    for (int t = 0; t < 8; t++) begin
      pc0 = 32'($urandom_range(0, 255)) * 32'd4;
      k   = (t == 0) ? 0 : int'($urandom_range(1, 40));
      lim = (t == 0) ? 5 : (t == 1 ? k : int'($urandom_range(0, 50)));
      set_pc(pc0);
      bp_en = 1'b1;
      bp_addr = pc0 + 32'(4 * k);
      cyc_limit = CNT_W'(lim);
      send_cmd(2'd0);
      measure_run(200, en, sp, to);
      // A breakpoint at the start pc is skipped once and never seen again.
      if (k > 0 && (lim == 0 || k <= lim)) begin
        exp_en = k; ec = 3'd2;
      end else begin
        exp_en = lim; ec = 3'd3;
      end
      exp_pc = pc0 + 32'(4 * exp_en);
      exp_cause = ec;
      total_cnt++;
      if (to || en !== exp_en || sp !== exp_pc || halt_cause !== ec || cyc_cnt !== CNT_W'(exp_en))
        $display("FAIL run%0d k=%0d lim=%0d: to=%0d en=%0d pc=%h cause=%0d cnt=%0d, want en=%0d pc=%h cause=%0d",
                 t, k, lim, to, en, sp, halt_cause, cyc_cnt, exp_en, exp_pc, ec);
      else pass_cnt++;
    end
  endtask

  task automatic test_limit;
    int en;
    logic [31:0] sp;
    bit to;
    set_pc(32'h1000);
    bp_en = 1'b0;
    cyc_limit = CNT_W'(1000);
    send_cmd(2'd0);
    measure_run(1100, en, sp, to);
    exp_cause = 3'd3;
    total_cnt++;
    if (to || en !== 1000 || halt_cause !== 3'd3 || cyc_cnt !== CNT_W'(1000))
      $display("FAIL limit_1000: to=%0d en=%0d cause=%0d cnt=%0d, want 0 1000 3 1000",
               to, en, halt_cause, cyc_cnt);
    else pass_cnt++;
  endtask

  task automatic test_step;
    logic [31:0] pc0;
    pc0 = cpu_pc;
    send_cmd(2'd1);
    total_cnt++;
    if (cmd_ready !== 1'b0 || cpu_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL step_cycle: rdy=%b en=%b busy=%b want 0 1 1", cmd_ready, cpu_en, busy);
    else pass_cnt++;
    @(negedge clk);
    exp_cause = 3'd5;
    total_cnt++;
    if (cmd_ready !== 1'b1 || cpu_en !== 1'b0 || halt_cause !== 3'd5 || pc !== pc0 + 32'd4 ||
        cyc_cnt !== CNT_W'(1001))
      $display("FAIL step_done: rdy=%b en=%b cause=%0d pc=%h cnt=%0d want 1 0 5 %h 1001",
               cmd_ready, cpu_en, halt_cause, pc, cyc_cnt, pc0 + 32'd4);
    else pass_cnt++;
    flt = 1'b1;
    send_cmd(2'd1);
    total_cnt++;
    if (cpu_en !== 1'b0) $display("FAIL step_fault_en: cpu_en=%b want 0", cpu_en);
    else pass_cnt++;
    @(negedge clk);
    flt = 1'b0;
    exp_cause = 3'd4;
    total_cnt++;
    if (halt_cause !== 3'd4 || busy !== 1'b0)
      $display("FAIL step_fault: cause=%0d busy=%b want 4 0", halt_cause, busy);
    else pass_cnt++;
  endtask

  task automatic test_ignore_and_fault_halt;
    set_pc(32'h200);
    bp_en = 1'b0;
    cyc_limit = '0;
    send_cmd(2'd0);
    repeat ($urandom_range(1, 10)) @(negedge clk);
    send_cmd(2'd1);
    send_cmd(2'd3);
    total_cnt++;
    if (busy !== 1'b1 || cpu_en !== 1'b1 || dump_valid !== 1'b0)
      $display("FAIL run_ignores: busy=%b en=%b dv=%b want 1 1 0", busy, cpu_en, dump_valid);
    else pass_cnt++;
    @(negedge clk);
    flt = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    #1;
    total_cnt++;
    if (cpu_en !== 1'b0) $display("FAIL fault_halt_en: cpu_en=%b want 0", cpu_en);
    else pass_cnt++;
    @(negedge clk);
    cmd_valid = 1'b0;
    flt = 1'b0;
    exp_cause = 3'd4;
    total_cnt++;
    if (halt_cause !== 3'd4 || busy !== 1'b0)
      $display("FAIL fault_halt: cause=%0d busy=%b want 4 0", halt_cause, busy);
    else pass_cnt++;
  endtask

  task automatic test_dump(input bit rand_data);
    int nvalid, first_c, last_c, done_c, ndone, bad;
    for (int i = 0; i < 32; i++) rf[i] = rand_data ? $urandom : 32'(i * 32'h11);
    send_cmd(2'd3);
    nvalid = 0; first_c = -1; last_c = -1; done_c = -1; ndone = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (dump_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (nvalid < 32 && (dump_idx !== 5'(nvalid) || dump_data !== rf[nvalid])) begin
          bad++;
          $display("FAIL dump_word%0d: idx=%0d data=%h want idx=%0d data=%h",
                   nvalid, dump_idx, dump_data, nvalid, rf[nvalid]);
        end
        nvalid++;
      end
      if (dump_done) begin
        ndone++;
        done_c = c;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (bad == 0) pass_cnt++;
    total_cnt++;
    if (nvalid !== 32 || first_c !== 1 || last_c !== 32 || ndone !== 1 || done_c !== 33)
      $display("FAIL dump_timing: n=%0d first=%0d last=%0d ndone=%0d done_at=%0d want 32 1 32 1 33",
               nvalid, first_c, last_c, ndone, done_c);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || halt_cause !== exp_cause)
      $display("FAIL dump_end: busy=%b cause=%0d want 0 %0d", busy, halt_cause, exp_cause);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_dump;
    bit hit;
    int ndv;
    hit = 1'b0;
    send_cmd(2'd3);
    for (int c = 0; c < 40; c++) begin
      if (dump_valid && dump_idx == 5'd10) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (!hit || {busy, cpu_en, dump_valid, dump_done, cmd_ready} !== 5'b00001 ||
        halt_cause !== 3'd0 || cyc_cnt !== '0 || reg_sel !== 5'd0)
      $display("FAIL reset_mid_dump: hit=%0d busy=%b en=%b dv=%b dd=%b rdy=%b cause=%0d cnt=%0d sel=%0d want 1 0 0 0 0 1 0 0 0",
               hit, busy, cpu_en, dump_valid, dump_done, cmd_ready, halt_cause, cyc_cnt, reg_sel);
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    ndv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dump_valid || dump_done || busy) ndv++;
    end
    total_cnt++;
    if (ndv !== 0) $display("FAIL post_reset_quiet: active_cycles=%0d want 0", ndv);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_breakpoint;
    test_resume;
    test_random_runs;
    test_limit;
    test_step;
    test_dump(1'b0);
    test_ignore_and_fault_halt;
    test_dump(1'b1);
    test_reset_mid_dump;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/scpu_runctl.md
SCPU_RUNCTL -- requirements
Module: scpu_runctl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the cycle-counter and limit width.
REQ-002 SHALL have parameter NREG, default 32, meaning the number of register-file entries dumped.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1, host command strobe.
REQ-006 SHALL have port cmd_op, input, 2, command code: 0 RUN, 1 STEP, 2 HALT, 3 DUMP.
REQ-007 SHALL have port cmd_ready, output, 1; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port bp_en, input, 1, breakpoint enable.
REQ-009 SHALL have port bp_addr, input, 32, breakpoint PC.
REQ-010 SHALL have port cyc_limit, input, CNT_W, cycle limit; 0 means unlimited.
REQ-011 SHALL have port pc, input, 32, the current CPU PC.
REQ-012 SHALL have port cpu_en, output, 1, CPU clock-enable; combinational from state, pc and flags.
REQ-013 SHALL have port reg_sel, output, 5, registered register-file read select.
REQ-014 SHALL have port reg_data, input, 32, combinational register-file read data for reg_sel.
REQ-015 SHALL have port dump_valid, output, 1, dump word strobe.
REQ-016 SHALL have port dump_idx, output, 5, index of the dumped word.
REQ-017 SHALL have port dump_data, output, 32, value of the dumped word.
REQ-018 SHALL have port dump_done, output, 1, one-cycle pulse after the last dump word.
REQ-019 SHALL have port halt_cause, output, 3: 0 NONE, 1 HOST, 2 BP, 3 LIMIT, 4 FAULT, 5 STEP.
REQ-020 SHALL have port cyc_cnt, output, CNT_W, the count of enabled CPU cycles.
REQ-021 SHALL have port busy, output, 1, high when state is not HALTED.

Function
REQ-022 SHALL implement the states HALTED, RUN, STEP and DUMP.
REQ-023 SHALL hold cmd_ready high in HALTED and RUN, and low in STEP and DUMP.
REQ-024 SHALL, in HALTED: on RUN, go to RUN, clear cyc_cnt and set the skip flag; on STEP, go to STEP; on DUMP, go to DUMP with the index at 0; on HALT, do nothing.
REQ-025 SHALL, in RUN, act only on HALT and ignore RUN, STEP and DUMP.
REQ-026 SHALL define stop conditions: fault = pc[1:0] != 0; bp = bp_en and pc == bp_addr and skip flag clear; limit = cyc_limit != 0 and cyc_cnt >= cyc_limit.
REQ-027 SHALL drive cpu_en = 1 in RUN only when no stop condition holds, so the instruction at the breakpoint is not executed.
REQ-028 SHALL, in RUN when a stop condition holds, drive cpu_en = 0, go to HALTED and latch halt_cause with priority FAULT > BP > LIMIT > HOST.
REQ-029 SHALL clear the skip flag after the first RUN cycle, so a RUN from a breakpoint PC executes that instruction.
REQ-030 SHALL, in STEP, drive cpu_en = 1 for exactly one cycle unless fault holds, then go to HALTED with halt_cause STEP, or FAULT with cpu_en = 0.
REQ-031 SHALL increment cyc_cnt on every cycle with cpu_en = 1, saturating at all-ones.
REQ-032 SHALL, in DUMP, drive reg_sel = idx and increment idx each cycle, capturing reg_data into dump_data with dump_idx = idx and dump_valid = 1 on the next cycle.
REQ-033 SHALL produce exactly NREG consecutive dump_valid pulses, pulse dump_done in the cycle after the last pulse and return to HALTED; halt_cause SHALL be unchanged.
REQ-034 SHALL hold cpu_en at 0 in HALTED and DUMP.

Reset
REQ-035 SHALL, on rstn low, immediately force state HALTED, halt_cause NONE, cyc_cnt 0, reg_sel 0, idx 0, skip 0, dump_valid 0, dump_done 0 and cpu_en 0.
REQ-036 SHALL abort any RUN, STEP or DUMP on reset, with no further dump pulses after release.

Verification
REQ-037 SHALL verify: bp_en=1, bp_addr=0x48, RUN, pc advancing by 4 from 0 -> cpu_en drops when pc=0x48, halt_cause=2, cyc_cnt=18.
REQ-038 SHALL verify: halted at bp 0x48, then RUN -> cpu_en=1 in the first cycle and pc moves past 0x48.
REQ-039 SHALL verify: cyc_limit=1000, bp_en=0, RUN -> exactly 1000 cpu_en cycles, halt_cause=3, cyc_cnt=1000.
REQ-040 SHALL verify: STEP from HALTED -> one cpu_en pulse, halt_cause=5, cmd_ready low for one cycle.
REQ-041 SHALL verify: DUMP with rf[i]=i*0x11 -> 32 consecutive dump_valid pulses, idx 0..31, data i*0x11, then dump_done.
REQ-042 SHALL verify: HALT command in the same cycle that pc=0x2 -> halt_cause=4 (FAULT) and cpu_en=0.
REQ-043 SHALL verify: rstn low at dump index 10 -> outputs return to reset values asynchronously.
